keypad_scanner: RTL and testbench

Parametrised matrix-keypad scanner with per-key debounce, ghost rejection, release detection and optional auto-repeat. It drives the column lines of an R×C keypad, samples the synchronised row lines, and emits single-cycle press/release events carrying a linear key index and a hex code. It sits between the board keypad pins and the seven-segment display/control logic, and replaces the fixed 4×4 decoder.

---
 rtl/keypad_pkg.sv | 39 +++
 rtl/keypad_col_scan.sv | 62 ++++++
 rtl/keypad_scanner.sv | 240 ++++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module   : keypad_pkg
// Purpose  : Shared types and helpers for the matrix keypad scanner:
//            frame classification, FSM states and the 4x4 hex legend LUT.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package keypad_pkg;

  // Result of one full pass over all columns.
  typedef enum logic [1:0] {
    NONE   = 2'd0,
    SINGLE = 2'd1,
    GHOST  = 2'd2
  } frame_class_t;

  // Debounce / hold state machine.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } state_t;

  // Legend printed on the standard 4x4 keypad.
  function automatic logic [3:0] hex_lut(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] v;
    unique case ({row, col})
      4'h0: v = 4'h1;  4'h1: v = 4'h2;  4'h2: v = 4'h3;  4'h3: v = 4'hA;
      4'h4: v = 4'h4;  4'h5: v = 4'h5;  4'h6: v = 4'h6;  4'h7: v = 4'hB;
      4'h8: v = 4'h7;  4'h9: v = 4'h8;  4'hA: v = 4'h9;  4'hB: v = 4'hC;
      4'hC: v = 4'h0;  4'hD: v = 4'hF;  4'hE: v = 4'hE;  default: v = 4'hD;
    endcase
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_col_scan.sv
`default_nettype none
// ============================================================================
// Module   : keypad_col_scan
// Purpose  : Column scan timebase. Drives one column low at a time for
//            SCAN_TICKS cycles and flags the row-sample and frame-end cycles.
// Ports    : clk, rst_n       - clock, async active-low reset
//            o_col            - one-hot-low column drive (registered)
//            o_col_idx        - index of the column currently driven
//            o_sample         - high on the cycle rows are to be sampled
//            o_frame_end      - high on the last cycle of a full frame
// Revision : 1.0 - initial release
// ============================================================================
module keypad_col_scan #(
  parameter int NUM_COLS     = 4,
  parameter int SCAN_TICKS   = 100000,
  parameter int SETTLE_TICKS = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic [NUM_COLS-1:0]         o_col,
  output logic [$clog2(NUM_COLS)-1:0] o_col_idx,
  output logic                        o_sample,
  output logic                        o_frame_end
);

  localparam int c_tw = $clog2(SCAN_TICKS);
  localparam int c_cw = $clog2(NUM_COLS);
  localparam logic [NUM_COLS-1:0] c_one = NUM_COLS'(1);

  logic [c_tw-1:0]     r_tick;
  logic [c_cw-1:0]     r_col_idx;
  logic [NUM_COLS-1:0] r_col;
  logic                w_tick_wrap;
  logic                w_last_col;
  logic [c_cw-1:0]     w_next_idx;

  assign w_tick_wrap = (r_tick == c_tw'(SCAN_TICKS - 1));
  assign w_last_col  = (r_col_idx == c_cw'(NUM_COLS - 1));
  assign w_next_idx  = w_last_col ? '0 : r_col_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick    <= '0;
      r_col_idx <= '0;
      r_col     <= ~c_one;
    end else if (w_tick_wrap) begin
      r_tick    <= '0;
      r_col_idx <= w_next_idx;
      // Column drive is registered so it switches together with the index.
      r_col     <= ~(c_one << w_next_idx);
    end else begin
      r_tick    <= r_tick + 1'b1;
    end
  end

  assign o_col       = r_col;
  assign o_col_idx   = r_col_idx;
  assign o_sample    = (r_tick == c_tw'(SETTLE_TICKS));
  assign o_frame_end = w_tick_wrap && w_last_col;

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner
// Purpose  : Matrix keypad scanner with debounce, ghost rejection, release
//            detection and optional auto-repeat.
// Ports    : clk, rst_n   - clock, async active-low reset
//            row          - raw active-low row lines (asynchronous)
//            col          - one-hot-low column drive
//            key_index    - r*NUM_COLS+c of the last accepted key
//            key_hex      - legend of key_index (0 unless 4x4)
//            key_press    - 1-cycle pulse: accepted press or auto-repeat
//            key_repeat   - qualifies key_press as a repeat
//            key_release  - 1-cycle pulse: accepted release
//            key_held     - high between accepted press and release
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int NUM_ROWS             = 4,
  parameter int NUM_COLS             = 4,
  parameter int SCAN_TICKS           = 100000,
  parameter int SETTLE_TICKS         = 8,
  parameter int DEBOUNCE_FRAMES      = 3,
  parameter int REPEAT_EN            = 0,
  parameter int REPEAT_DELAY_FRAMES  = 50,
  parameter int REPEAT_PERIOD_FRAMES = 10
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_ROWS-1:0]                  row,
  output logic [NUM_COLS-1:0]                  col,
  output logic [$clog2(NUM_ROWS*NUM_COLS)-1:0] key_index,
  output logic [3:0]                           key_hex,
  output logic                                 key_press,
  output logic                                 key_repeat,
  output logic                                 key_release,
  output logic                                 key_held
);

  localparam int c_iw      = $clog2(NUM_ROWS * NUM_COLS);
  localparam int c_cw      = $clog2(NUM_COLS);
  localparam int c_dbw     = $clog2(DEBOUNCE_FRAMES + 1);
  localparam int c_rep_max = (REPEAT_DELAY_FRAMES > REPEAT_PERIOD_FRAMES) ?
                             REPEAT_DELAY_FRAMES : REPEAT_PERIOD_FRAMES;
  localparam int c_rw      = $clog2(c_rep_max + 1);
  localparam bit c_is_4x4  = (NUM_ROWS == 4) && (NUM_COLS == 4);

  // Row synchroniser
  logic [NUM_ROWS-1:0] r_row_s1, r_row_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row_s1 <= '1;
      r_row_s2 <= '1;
    end else begin
      r_row_s1 <= row;
      r_row_s2 <= r_row_s1;
    end
  end

  // Column timebase
  logic [c_cw-1:0] w_col_idx;
  logic            w_sample;
  logic            w_frame_end;

  keypad_col_scan #(
    .NUM_COLS     (NUM_COLS),
    .SCAN_TICKS   (SCAN_TICKS),
    .SETTLE_TICKS (SETTLE_TICKS)
  ) u_col_scan (
    .clk         (clk),
    .rst_n       (rst_n),
    .o_col       (col),
    .o_col_idx   (w_col_idx),
    .o_sample    (w_sample),
    .o_frame_end (w_frame_end)
  );

  // Frame accumulator. The next-value view folds in the current sample so a
  // sample landing on the frame-end cycle is still counted in that frame.
  logic [1:0]      r_hit_cnt;
  logic [c_iw-1:0] r_hit_idx;
  logic            r_cand_hit;
  logic [1:0]      w_acc_cnt;
  logic [c_iw-1:0] w_acc_idx;
  logic            w_acc_cand;
  logic [c_iw-1:0] w_lin;
  logic [c_iw-1:0] r_cand;

  always_comb begin
    w_acc_cnt  = r_hit_cnt;
    w_acc_idx  = r_hit_idx;
    w_acc_cand = r_cand_hit;
    w_lin      = '0;
    if (w_sample) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        if (!r_row_s2[r]) begin
          w_lin     = c_iw'(r * NUM_COLS) + c_iw'(w_col_idx);
          w_acc_cnt = (w_acc_cnt == 2'd2) ? 2'd2 : w_acc_cnt + 2'd1;
          w_acc_idx = w_lin;
          // Presence of the candidate is tracked even inside a ghost frame.
          if (w_lin == r_cand) w_acc_cand = 1'b1;
        end
      end
    end
  end

  frame_class_t    r_cls;
  logic [c_iw-1:0] r_cls_idx;
  logic            r_cls_cand;
  logic            r_cls_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_cnt  <= '0;
      r_hit_idx  <= '0;
      r_cand_hit <= 1'b0;
      r_cls      <= NONE;
      r_cls_idx  <= '0;
      r_cls_cand <= 1'b0;
      r_cls_vld  <= 1'b0;
    end else if (w_frame_end) begin
      r_hit_cnt  <= '0;
      r_hit_idx  <= '0;
      r_cand_hit <= 1'b0;
      r_cls      <= (w_acc_cnt == 2'd0) ? NONE : (w_acc_cnt == 2'd1) ? SINGLE : GHOST;
      r_cls_idx  <= w_acc_idx;
      r_cls_cand <= w_acc_cand;
      r_cls_vld  <= 1'b1;
    end else begin
      r_hit_cnt  <= w_acc_cnt;
      r_hit_idx  <= w_acc_idx;
      r_cand_hit <= w_acc_cand;
      r_cls_vld  <= 1'b0;
    end
  end

  // Legend of the classified key; only used when it is being accepted.
  logic [3:0] w_idx4;
  logic [3:0] w_cls_hex;

  assign w_idx4    = 4'(r_cls_idx);
  assign w_cls_hex = c_is_4x4 ? hex_lut(w_idx4[3:2], w_idx4[1:0]) : 4'h0;

  // Debounce FSM with repeat counter
  state_t           r_state;
  logic [c_dbw-1:0] r_db_cnt;
  logic [c_rw-1:0]  r_rep_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_db_cnt    <= '0;
      r_rep_cnt   <= '0;
      r_cand      <= '0;
      key_index   <= '0;
      key_hex     <= 4'h0;
      key_press   <= 1'b0;
      key_repeat  <= 1'b0;
      key_release <= 1'b0;
      key_held    <= 1'b0;
    end else begin
      key_press   <= 1'b0;
      key_repeat  <= 1'b0;
      key_release <= 1'b0;
      if (r_cls_vld) begin
        unique case (r_state)
          IDLE: begin
            if (r_cls == SINGLE) begin
              r_cand <= r_cls_idx;
              if (DEBOUNCE_FRAMES == 1) begin
                r_state   <= HELD;
                key_index <= r_cls_idx;
                key_hex   <= w_cls_hex;
                key_press <= 1'b1;
                key_held  <= 1'b1;
                r_rep_cnt <= c_rw'(REPEAT_DELAY_FRAMES);
              end else begin
                r_state  <= PRESS_DB;
                r_db_cnt <= c_dbw'(1);
              end
            end
          end
          PRESS_DB: begin
            if (r_cls == SINGLE && r_cls_idx == r_cand) begin
              if (r_db_cnt == c_dbw'(DEBOUNCE_FRAMES - 1)) begin
                r_state   <= HELD;
                key_index <= r_cls_idx;
                key_hex   <= w_cls_hex;
                key_press <= 1'b1;
                key_held  <= 1'b1;
                r_rep_cnt <= c_rw'(REPEAT_DELAY_FRAMES);
              end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
              end
            end else begin
              r_state <= IDLE;
            end
          end
          HELD: begin
            if (r_cls_cand) begin
              // Down-counter reaching 1 marks the frame that owes a repeat.
              if (REPEAT_EN != 0) begin
                if (r_rep_cnt <= c_rw'(1)) begin
                  key_press  <= 1'b1;
                  key_repeat <= 1'b1;
                  r_rep_cnt  <= c_rw'(REPEAT_PERIOD_FRAMES);
                end else begin
                  r_rep_cnt <= r_rep_cnt - 1'b1;
                end
              end
            end else if (DEBOUNCE_FRAMES == 1) begin
              r_state     <= IDLE;
              key_release <= 1'b1;
              key_held    <= 1'b0;
            end else begin
              r_state  <= REL_DB;
              r_db_cnt <= c_dbw'(1);
            end
          end
          REL_DB: begin
            if (r_cls_cand) begin
              r_state <= HELD;
            end else if (r_db_cnt == c_dbw'(DEBOUNCE_FRAMES - 1)) begin
              r_state     <= IDLE;
              key_release <= 1'b1;
              key_held    <= 1'b0;
            end else begin
              r_db_cnt <= r_db_cnt + 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scanner
// Purpose  : Self-checking bench for keypad_scanner (4x4, 16-tick columns).
//            A plain instance and an auto-repeat instance share clock/reset;
//            a keypad model closes rows onto driven columns.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [15:0] keys_a, keys_b;
  logic [3:0]  row_a, col_a, idx_a, hex_a;
  logic [3:0]  row_b, col_b, idx_b, hex_b;
  logic        press_a, rep_a, rel_a, held_a;
  logic        press_b, rep_b, rel_b, held_b;

  keypad_scanner #(
    .NUM_ROWS(4), .NUM_COLS(4), .SCAN_TICKS(16), .SETTLE_TICKS(4),
    .DEBOUNCE_FRAMES(3), .REPEAT_EN(0),
    .REPEAT_DELAY_FRAMES(4), .REPEAT_PERIOD_FRAMES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .row(row_a), .col(col_a),
    .key_index(idx_a), .key_hex(hex_a), .key_press(press_a),
    .key_repeat(rep_a), .key_release(rel_a), .key_held(held_a)
  );

  keypad_scanner #(
    .NUM_ROWS(4), .NUM_COLS(4), .SCAN_TICKS(16), .SETTLE_TICKS(4),
    .DEBOUNCE_FRAMES(3), .REPEAT_EN(1),
    .REPEAT_DELAY_FRAMES(4), .REPEAT_PERIOD_FRAMES(2)
  ) dut_rep (
    .clk(clk), .rst_n(rst_n), .row(row_b), .col(col_b),
    .key_index(idx_b), .key_hex(hex_b), .key_press(press_b),
    .key_repeat(rep_b), .key_release(rel_b), .key_held(held_b)
  );

  // Keypad model: a closed key pulls its row low while its column is driven.
  always_comb begin
    row_a = 4'hF;
    row_b = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys_a[r*4+c] && !col_a[c]) row_a[r] = 1'b0;
        if (keys_b[r*4+c] && !col_b[c]) row_b[r] = 1'b0;
      end
    end
  end

  // Cycles since reset release; a frame is 64 cycles, frame k ends at 64k+63
  // and its events appear two cycles later at 64k+65.
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit         rel;
    bit         rep;
    logic [3:0] idx;
    logic [3:0] hex;
    int         cyc;
  } ev_t;

  ev_t q_a[$];
  ev_t q_b[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] pack(input int c, input bit p, input bit r,
                                       input bit rp, input bit h,
                                       input logic [3:0] i, input logic [3:0] x);
    return {32'(c), 20'h0, p, r, rp, h, i, x};
  endfunction

  function automatic logic [15:0] k(input int r, input int c);
    logic [15:0] one;
    one = 16'h1;
    return one << (r * 4 + c);
  endfunction

  task automatic check_ev(input bit sel);
    logic [63:0] act;
    ev_t e;
    if (sel) act = pack(cyc, press_b, rel_b, rep_b, held_b, idx_b, hex_b);
    else     act = pack(cyc, press_a, rel_a, rep_a, held_a, idx_a, hex_a);
    if ((sel ? q_b.size() : q_a.size()) == 0) begin
      chk(sel ? "unexpected_event_b" : "unexpected_event_a", act, 64'h0);
    end else begin
      e = sel ? q_b.pop_front() : q_a.pop_front();
      chk(sel ? "event_b" : "event_a", act,
          pack(e.cyc, !e.rel, e.rel, e.rep, !e.rel, e.idx, e.hex));
    end
  endtask

  // Monitor: every output event is matched against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (press_a || rel_a) check_ev(1'b0);
        if (press_b || rel_b) check_ev(1'b1);
      end
    end
  end

  // Wait for the quiet point late in the last column, then change keys so
  // the new pattern covers whole frames starting with frame f0.
  task automatic seg(input bit sel, input logic [15:0] m, output int f0);
    int g;
    g = 0;
    while ((cyc % 64) != 60 && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (sel) keys_b = m;
    else     keys_a = m;
    f0 = (cyc + 4) / 64;
  endtask

  task automatic frames(input int n);
    repeat (64 * n) @(negedge clk);
  endtask

  task automatic exp_ev(input bit sel, input bit rel, input bit rep,
                        input logic [3:0] idx, input logic [3:0] hex, input int frame);
    ev_t e;
    e.rel = rel; e.rep = rep; e.idx = idx; e.hex = hex;
    e.cyc = 64 * frame + 65;
    if (sel) q_b.push_back(e);
    else     q_a.push_back(e);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    int g;
    logic [3:0] col_seq [5];
    col_seq[0] = 4'b1110; col_seq[1] = 4'b1101; col_seq[2] = 4'b1011;
    col_seq[3] = 4'b0111; col_seq[4] = 4'b1110;

    rst_n  = 1'b0;
    keys_a = 16'h0;
    keys_b = 16'h0;
    repeat (3) @(negedge clk);
    chk("reset_col_a", 64'(col_a), 64'(4'b1110));
    chk("reset_out_a", 64'({idx_a, hex_a, press_a, rep_a, rel_a, held_a}), 64'h0);
    chk("reset_col_b", 64'(col_b), 64'(4'b1110));

    // Reset in the middle of the third column.
    rst_n = 1'b1;
    repeat (37) @(negedge clk);
    chk("col_mid_frame", 64'(col_a), 64'(4'b1011));
    rst_n = 1'b0;
    #1;
    chk("midreset_col", 64'(col_a), 64'(4'b1110));
    chk("midreset_out", 64'({idx_a, hex_a, press_a, rep_a, rel_a, held_a}), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      g = 0;
      while (cyc != 5 + 16 * i && g < 100) begin
        @(negedge clk);
        g++;
      end
      chk("col_step", 64'(col_a), 64'(col_seq[i]));
    end

    // Stable key row0/col3 for 5 frames: press after the third frame.
    seg(1'b0, k(0, 3), f0);
    exp_ev(1'b0, 1'b0, 1'b0, 4'd3, 4'hA, f0 + 2);
    frames(5);
    chk("held_after_press", 64'(held_a), 64'h1);

    // Release: three empty frames.
    seg(1'b0, 16'h0, f0);
    exp_ev(1'b0, 1'b1, 1'b0, 4'd3, 4'hA, f0 + 2);
    frames(4);
    chk("after_release", 64'({held_a, idx_a, hex_a}), 64'({1'b0, 4'd3, 4'hA}));

    // Bounce on row1/col2: present, absent, then steady.
    seg(1'b0, k(1, 2), f0); frames(1);
    seg(1'b0, 16'h0,   f0); frames(1);
    seg(1'b0, k(1, 2), f0);
    exp_ev(1'b0, 1'b0, 1'b0, 4'd6, 4'h6, f0 + 2);
    frames(4);
    seg(1'b0, 16'h0, f0);
    exp_ev(1'b0, 1'b1, 1'b0, 4'd6, 4'h6, f0 + 2);
    frames(4);

    // Two keys together from idle never produce a press.
    seg(1'b0, k(1, 1) | k(2, 2), f0); frames(6);
    seg(1'b0, 16'h0, f0); frames(2);
    chk("ghost_no_press", 64'({held_a, idx_a}), 64'({1'b0, 4'd6}));

    // Ghost that still contains the held key keeps it held; a different key
    // alone counts as release and is not itself accepted afterwards.
    seg(1'b0, k(0, 3), f0);
    exp_ev(1'b0, 1'b0, 1'b0, 4'd3, 4'hA, f0 + 2);
    frames(3);
    seg(1'b0, k(0, 3) | k(2, 1), f0); frames(3);
    chk("held_through_ghost", 64'(held_a), 64'h1);
    seg(1'b0, k(2, 1), f0);
    exp_ev(1'b0, 1'b1, 1'b0, 4'd3, 4'hA, f0 + 2);
    frames(4);
    seg(1'b0, 16'h0, f0); frames(3);
    chk("swap_key_not_taken", 64'({held_a, idx_a}), 64'({1'b0, 4'd3}));

    // Row3/col0 carries legend 0.
    seg(1'b0, k(3, 0), f0);
    exp_ev(1'b0, 1'b0, 1'b0, 4'd12, 4'h0, f0 + 2);
    frames(3);
    seg(1'b0, 16'h0, f0);
    exp_ev(1'b0, 1'b1, 1'b0, 4'd12, 4'h0, f0 + 2);
    frames(4);

    // Reset during a press debounce: no event, outputs cleared.
    seg(1'b0, k(0, 0), f0); frames(2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset_in_debounce", 64'({col_a, idx_a, hex_a, press_a, held_a}),
        64'({4'b1110, 4'd0, 4'h0, 1'b0, 1'b0}));
    keys_a = 16'h0;
    @(negedge clk);
    rst_n = 1'b1;
    frames(5);

    // Auto-repeat on row3/col1: press, then repeats 4 and 6 frames later.
    seg(1'b1, k(3, 1), f0);
    exp_ev(1'b1, 1'b0, 1'b0, 4'd13, 4'hF, f0 + 2);
    exp_ev(1'b1, 1'b0, 1'b1, 4'd13, 4'hF, f0 + 6);
    exp_ev(1'b1, 1'b0, 1'b1, 4'd13, 4'hF, f0 + 8);
    frames(10);
    seg(1'b1, 16'h0, f0);
    exp_ev(1'b1, 1'b1, 1'b0, 4'd13, 4'hF, f0 + 2);
    frames(4);
    chk("rep_released", 64'({held_b, idx_b}), 64'({1'b0, 4'd13}));

    frames(1);
    chk("pending_events_a", 64'(q_a.size()), 64'h0);
    chk("pending_events_b", 64'(q_b.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
